// File: rtl/score_keeper.sv
// score_keeper: turns accepted enemy hits into points for the six-digit
// score display. Hits pass through a two-stage pipeline (multiply, then
// accumulate with saturation). A frame-timed combo multiplier, a high score
// and extra-life pulses are also maintained. A small game-phase FSM gates
// when hits are accepted and when the high score is committed.
module score_keeper #(
  parameter int MAX_SCORE     = 999999,
  parameter int COMBO_TIMEOUT = 120,
  parameter int COMBO_MAX     = 4,
  parameter int LIFE_STEP     = 10000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        frame_tick,
  input  logic        new_game,
  input  logic        game_over,
  input  logic        hit_valid,
  input  logic [1:0]  hit_type,
  output logic        hit_ready,
  output logic [19:0] score,
  output logic [19:0] hiscore,
  output logic [2:0]  multiplier,
  output logic        extra_life
);

  localparam int TW = $clog2(COMBO_TIMEOUT + 1);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] PLAY  = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;
  localparam logic [1:0] OVER  = 2'd3;

  logic [1:0]    state;
  logic          accept;
  logic          start;
  logic [6:0]    base_pts;
  logic          s1_valid;
  logic [9:0]    s1_product;
  logic [20:0]   sum;
  logic [19:0]   new_score;
  logic [20:0]   threshold;
  logic [TW-1:0] timer;

  // Hits are only taken while playing; game_over in PLAY still accepts the
  // coincident hit because the state changes only at the next edge.
  assign hit_ready = (state == PLAY);
  assign accept    = hit_valid & hit_ready;
  assign start     = (state == IDLE) & new_game;

  // Base points per enemy class.
  always_comb begin
    // NOTE: a default before the case keeps this purely combinational; a
    // path that leaves base_pts unassigned would infer a latch.
    base_pts = 7'd10;
    case (hit_type)
      2'd0: base_pts = 7'd10;
      2'd1: base_pts = 7'd20;
      2'd2: base_pts = 7'd50;
      2'd3: base_pts = 7'd100;
      default: base_pts = 7'd10;
    endcase
  end

  // Stage-2 accumulate with clamp to the saturation ceiling.
  always_comb begin
    sum       = {1'b0, score} + {11'd0, s1_product};
    new_score = (sum > 21'(MAX_SCORE)) ? 20'(MAX_SCORE) : sum[19:0];
  end

  // Game-phase FSM; DRAIN leaves once stage 1 holds nothing, since the
  // stage-2 result lands in score on that same edge.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE:    if (new_game)  state <= PLAY;
        PLAY:    if (game_over) state <= DRAIN;
        DRAIN:   if (!s1_valid) state <= OVER;
        OVER:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // High score is committed only in the one-cycle OVER phase.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hiscore <= '0;
    end else if (state == OVER && score > hiscore) begin
      hiscore <= score;
    end
  end

  // Stage 1: base points times the multiplier in force at acceptance.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid   <= 1'b0;
      s1_product <= '0;
    end else begin
      s1_valid <= accept;
      if (accept) begin
        s1_product <= {3'd0, base_pts} * {7'd0, multiplier};
      end
    end
  end

  // Stage 2: score update and extra-life award. A single hit adds at most
  // 700 points, far less than LIFE_STEP, so one step always moves the
  // threshold past the new score.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      score      <= '0;
      threshold  <= 21'(LIFE_STEP);
      extra_life <= 1'b0;
    end else begin
      extra_life <= 1'b0;
      if (start) begin
        score     <= '0;
        threshold <= 21'(LIFE_STEP);
      end else if (s1_valid) begin
        score <= new_score;
        if ({1'b0, new_score} >= threshold && threshold <= 21'(MAX_SCORE)) begin
          extra_life <= 1'b1;
          threshold  <= threshold + 21'(LIFE_STEP);
        end
      end
    end
  end

  // Combo: a hit bumps the multiplier and reloads the timer (winning over a
  // coincident frame_tick); otherwise the timer counts frames down and the
  // multiplier falls back to 1 when it expires.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      multiplier <= 3'd1;
      timer      <= '0;
    end else if (start) begin
      multiplier <= 3'd1;
      timer      <= '0;
    end else if (accept) begin
      multiplier <= (multiplier >= 3'(COMBO_MAX)) ? 3'(COMBO_MAX) : multiplier + 3'd1;
      timer      <= TW'(COMBO_TIMEOUT);
    end else if (frame_tick && timer != '0) begin
      timer <= timer - 1'b1;
      if (timer == TW'(1)) begin
        multiplier <= 3'd1;
      end
    end
  end

endmodule

// File: tb/tb_score_keeper.sv
// tb_score_keeper: directed scenarios plus randomized traffic, all compared
// every cycle against a transaction-level reference model (pending-hit queue
// with due cycles, plain arithmetic for saturation and life thresholds).
module tb_score_keeper;

  localparam int MAX_SCORE     = 999999;
  localparam int COMBO_TIMEOUT = 120;
  localparam int COMBO_MAX     = 4;
  localparam int LIFE_STEP     = 10000;

  localparam int P_IDLE  = 0;
  localparam int P_PLAY  = 1;
  localparam int P_DRAIN = 2;
  localparam int P_OVER  = 3;

  logic        clk;
  logic        rst_n;
  logic        frame_tick;
  logic        new_game;
  logic        game_over;
  logic        hit_valid;
  logic [1:0]  hit_type;
  logic        hit_ready;
  logic [19:0] score;
  logic [19:0] hiscore;
  logic [2:0]  multiplier;
  logic        extra_life;

  score_keeper #(
    .MAX_SCORE(MAX_SCORE),
    .COMBO_TIMEOUT(COMBO_TIMEOUT),
    .COMBO_MAX(COMBO_MAX),
    .LIFE_STEP(LIFE_STEP)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .frame_tick(frame_tick),
    .new_game(new_game),
    .game_over(game_over),
    .hit_valid(hit_valid),
    .hit_type(hit_type),
    .hit_ready(hit_ready),
    .score(score),
    .hiscore(hiscore),
    .multiplier(multiplier),
    .extra_life(extra_life)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    int due;
    int pts;
  } pend_t;

  pend_t pq[$];
  int    cyc;
  int    m_phase, m_score, m_hi, m_mult, m_timer, m_thresh, m_life;

  function automatic int base_of(input int t);
    case (t)
      0: return 10;
      1: return 20;
      2: return 50;
      default: return 100;
    endcase
  endfunction

  task automatic model_reset();
    pq.delete();
    cyc      = 0;
    m_phase  = P_IDLE;
    m_score  = 0;
    m_hi     = 0;
    m_mult   = 1;
    m_timer  = 0;
    m_thresh = LIFE_STEP;
    m_life   = 0;
  endtask

  task automatic model_step(input bit v, input int t, input bit ng, input bit go, input bit ft);
    bit pending;
    bit acc;
    int nv;
    pend_t e;
    cyc++;
    pending = (pq.size() > 0) && (pq[0].due == cyc);
    acc     = v && (m_phase == P_PLAY);
    m_life  = 0;
    if (pending) begin
      e  = pq.pop_front();
      nv = m_score + e.pts;
      if (nv > MAX_SCORE) nv = MAX_SCORE;
      if (nv >= m_thresh && m_thresh <= MAX_SCORE) begin
        m_life   = 1;
        m_thresh = (nv / LIFE_STEP + 1) * LIFE_STEP;
      end
      m_score = nv;
    end
    if (acc) begin
      pq.push_back('{cyc + 1, base_of(t) * m_mult});
      m_mult  = (m_mult + 1 > COMBO_MAX) ? COMBO_MAX : m_mult + 1;
      m_timer = COMBO_TIMEOUT;
    end else if (ft && m_timer > 0) begin
      m_timer--;
      if (m_timer == 0) m_mult = 1;
    end
    case (m_phase)
      P_IDLE: if (ng) begin
        m_score  = 0;
        m_mult   = 1;
        m_timer  = 0;
        m_thresh = LIFE_STEP;
        m_phase  = P_PLAY;
      end
      P_PLAY:  if (go) m_phase = P_DRAIN;
      P_DRAIN: if (!pending) m_phase = P_OVER;
      default: begin
        if (m_score > m_hi) m_hi = m_score;
        m_phase = P_IDLE;
      end
    endcase
  endtask

  task automatic compare_all();
    check("score", int'(score), m_score);
    check("hiscore", int'(hiscore), m_hi);
    check("multiplier", int'(multiplier), m_mult);
    check("extra_life", int'(extra_life), m_life);
    check("hit_ready", int'(hit_ready), (m_phase == P_PLAY) ? 1 : 0);
  endtask

  // ---------------- stimulus helpers ----------------
  // Apply one cycle of inputs, advance the model at the edge, compare at the
  // falling edge, then return pulse inputs to idle.
  task automatic drive(input bit v, input int t, input bit ng, input bit go, input bit ft);
    hit_valid  = v;
    hit_type   = 2'(t);
    new_game   = ng;
    game_over  = go;
    frame_tick = ft;
    @(posedge clk);
    model_step(v, t, ng, go, ft);
    @(negedge clk);
    compare_all();
    hit_valid  = 1'b0;
    new_game   = 1'b0;
    game_over  = 1'b0;
    frame_tick = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(0, 0, 0, 0, 0);
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) drive(0, 0, 0, 0, 1);
  endtask

  task automatic burst(input int t, input int n);
    for (int i = 0; i < n; i++) drive(1, t, 0, 0, 0);
  endtask

  // Asynchronous reset asserted between edges; outputs must clear at once.
  task automatic reset_now();
    rst_n = 1'b0;
    #1;
    check("rst_async_score", int'(score), 0);
    check("rst_async_mult", int'(multiplier), 1);
    check("rst_async_ready", int'(hit_ready), 0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    compare_all();
  endtask

  initial begin
    rst_n      = 1'b0;
    frame_tick = 1'b0;
    new_game   = 1'b0;
    game_over  = 1'b0;
    hit_valid  = 1'b0;
    hit_type   = 2'd0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    compare_all();

    // First hit: ready one cycle after new_game, score two cycles after accept.
    drive(0, 0, 1, 0, 0);
    check("ready_after_new_game", int'(hit_ready), 1);
    drive(1, 3, 0, 0, 0);
    check("mult_after_first_hit", int'(multiplier), 2);
    check("score_one_cycle", int'(score), 0);
    idle(1);
    check("score_two_cycles", int'(score), 100);

    // Timeout: multiplier holds through 119 ticks and drops on the 120th.
    ticks(119);
    check("mult_tick119", int'(multiplier), 2);
    ticks(1);
    check("mult_tick120", int'(multiplier), 1);

    // Back-to-back type-0 hits: +10,+20,+30,+40,+40.
    burst(0, 5);
    idle(2);
    check("burst_score", int'(score), 240);
    check("burst_mult", int'(multiplier), 4);

    // Hit coincident with frame_tick reloads the timer.
    ticks(60);
    drive(1, 0, 0, 0, 1);
    ticks(119);
    check("reload_mult_hold", int'(multiplier), 4);
    ticks(1);
    check("reload_mult_drop", int'(multiplier), 1);

    // game_over with one hit in S1 and one accepted the same cycle; a
    // new_game during DRAIN is ignored.
    drive(1, 2, 0, 0, 0);
    drive(1, 1, 0, 1, 0);
    check("ready_on_go_cycle_dropped", int'(hit_ready), 0);
    drive(0, 0, 1, 0, 0);
    idle(4);
    check("drain_both_added", int'(score), 240 + 40 + 50 + 40);
    check("hiscore_first_game", int'(hiscore), 370);

    // Extra life: build 9990, then a 20-point hit at multiplier 1.
    drive(0, 0, 1, 0, 0);
    burst(3, 26);
    ticks(COMBO_TIMEOUT);
    drive(1, 2, 0, 0, 0);
    drive(1, 1, 0, 0, 0);
    drive(1, 1, 0, 0, 0);
    drive(1, 0, 0, 0, 0);
    ticks(COMBO_TIMEOUT);
    idle(1);
    check("pre_life_score", int'(score), 9990);
    drive(1, 1, 0, 0, 0);
    drive(0, 0, 0, 0, 0);
    check("life_score", int'(score), 10010);
    check("life_pulse", int'(extra_life), 1);
    idle(1);
    check("life_pulse_end", int'(extra_life), 0);
    burst(3, 30);
    idle(2);
    drive(0, 0, 0, 1, 0);
    idle(4);

    // Saturation at the ceiling; further hits change nothing and award nothing.
    drive(0, 0, 1, 0, 0);
    burst(3, 2600);
    idle(2);
    check("sat_score", int'(score), MAX_SCORE);
    drive(1, 3, 0, 0, 0);
    idle(1);
    check("sat_hold", int'(score), MAX_SCORE);
    check("sat_no_life", int'(extra_life), 0);
    drive(0, 0, 0, 1, 0);
    idle(4);
    check("hiscore_max", int'(hiscore), MAX_SCORE);

    // Reset mid-pipeline discards the in-flight hit.
    drive(0, 0, 1, 0, 0);
    burst(3, 3);
    reset_now();
    idle(3);
    check("post_reset_score", int'(score), 0);

    // Randomized traffic.
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 1499) == 0) begin
        reset_now();
      end else begin
        drive($urandom_range(0, 1) == 1, int'($urandom_range(0, 3)),
              $urandom_range(0, 19) == 0, $urandom_range(0, 149) == 0,
              $urandom_range(0, 3) == 0);
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/score_keeper.md
Name: score_keeper

Overview:
Upstream producer of the 20-bit score consumed by the six-digit score display. Converts enemy-hit events into points, applying a frame-timed combo multiplier. Saturates the score at 999999, keeps a high score and issues extra-life pulses. Sequenced by a game-phase FSM driven by new_game/game_over from the game controller.

Parameters:
MAX_SCORE, 999999, saturation ceiling of score (fits 20 bits).
COMBO_TIMEOUT, 120, frames after a hit during which the next hit continues the combo.
COMBO_MAX, 4, maximum multiplier value (1..7 legal).
LIFE_STEP, 10000, score interval between extra-life awards.

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
frame_tick  input  1  one-cycle pulse per video frame
new_game  input  1  one-cycle pulse: start a game
game_over  input  1  one-cycle pulse: end the current game
hit_valid  input  1  hit event offered this cycle
hit_type  input  2  enemy class: 0=10, 1=20, 2=50, 3=100 base points
hit_ready  output  1  hits accepted this cycle (hit_valid & hit_ready)
score  output  20  current score, binary, to the display's score input
hiscore  output  20  best score since reset
multiplier  output  3  multiplier applied to the next accepted hit
extra_life  output  1  one-cycle pulse on crossing a LIFE_STEP multiple

Behaviour:
- Clock and reset: one clock clk; reset is asynchronous, active-low (rst_n); all state clears immediately on rst_n=0.
- Reset values: score=0, hiscore=0, multiplier=1, extra_life=0, hit_ready=0, FSM=IDLE, combo timer=0, pipeline empty, next life threshold=LIFE_STEP.
- FSM states:
  - IDLE: score held. On new_game: score<=0, multiplier<=1, timer<=0, threshold<=LIFE_STEP; go to PLAY next cycle.
  - PLAY: hit_ready=1. On game_over: go to DRAIN; hit_ready drops the following cycle. A hit offered in the same cycle as game_over is accepted.
  - DRAIN: hit_ready=0. Wait until both pipeline stages are empty, then go to OVER.
  - OVER: single cycle. If score>hiscore, hiscore<=score. Then go to IDLE.
  - new_game outside IDLE and game_over outside PLAY are ignored.
- Pipeline: two stages, one hit per cycle, fully pipelined.
  - S1 (cycle after accept): product = base(hit_type) * multiplier, registered at 10 bits; maximum is 100*7=700.
  - S2 (next cycle): sum = score + product, computed at 21 bits. score <= min(sum, MAX_SCORE).
  - score reflects an accepted hit exactly 2 cycles after acceptance.
  - Back-to-back hits update score on consecutive cycles; none are lost.
- Combo (evaluated at accept):
  - The hit uses the current multiplier; then multiplier <= min(multiplier+1, COMBO_MAX) and timer <= COMBO_TIMEOUT.
  - Otherwise, on frame_tick with timer>0: timer decrements; on the transition to 0, multiplier <= 1.
  - Hit and frame_tick in the same cycle: the hit wins (reload, no decrement).
- Extra life (in S2):
  - If the new score >= threshold and threshold <= MAX_SCORE: extra_life=1 for one cycle, and threshold advances by LIFE_STEP past the new score.
  - At most one pulse per hit, even if multiple steps are crossed.
  - No pulse once threshold > MAX_SCORE.
- Saturation: once score=MAX_SCORE, further hits leave it unchanged; multiplier and timer still update.
- Reset mid-game: everything returns to reset values at once; in-flight pipeline hits are discarded.

Test Plan:
- Reset, new_game, one hit_type=3 -> hit_ready=1 from 1 cycle after new_game; score=100 exactly 2 cycles after accept; multiplier=2 the cycle after accept.
- Five consecutive-cycle hits of type 0 -> score sequence 10,30,60,100,140 (multipliers 1,2,3,4,4); multiplier stays 4.
- Hit, then 120 frame_ticks with no hits -> multiplier returns to 1 on the 120th tick. frame_tick coincident with a hit -> timer reloads to 120.
- Preload score to 999950 via hits; hit type 3 at multiplier 4 -> score=999999. A further hit keeps 999999 and gives no extra_life.
- Score 9990, hit type 1 at multiplier 1 -> score=10010, one extra_life pulse in the same cycle score updates. Next pulse only at >=20000.
- game_over with a hit in S1 and a hit accepted the same cycle -> both added. hiscore updates in OVER only if greater (e.g. 10010>0). new_game during DRAIN is ignored. rst_n low mid-pipeline -> score=0 immediately.
